// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer reader and its timing generator:
// fetch FSM states, pixel width and 800x480 display timing constants.
package vga_pkg;

    localparam int RGB_W = 24;

    localparam int H_DISP  = 800;
    localparam int H_FP    = 40;
    localparam int H_SYNC  = 48;
    localparam int H_BP    = 88;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP  = 480;
    localparam int V_FP    = 13;
    localparam int V_SYNC  = 3;
    localparam int V_BP    = 32;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fb_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock show-ahead pixel FIFO. The head word is kept in a register so
// the output is valid the cycle after a push into an empty FIFO.
module pixel_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_nxt_s;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop_s;

    // Pointer, level and head-register next state.
    always_comb begin
        do_pop_s = pop && (level_q != LW'(0));
        rd_nxt_s = rd_ptr_q + AW'(1);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            level_d  = LW'(0);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_nxt_s;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, do_pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // New data bypasses storage when it becomes the head immediately.
            if (push && ((level_q == LW'(0)) || ((level_q == LW'(1)) && do_pop_s))) begin
                head_d = wr_data;
            end else if (do_pop_s && (level_q > LW'(1))) begin
                head_d = mem_q[rd_nxt_s];
            end else begin
                head_d = head_q;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
            head_q   <= WIDTH'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign rd_data = head_q;
    assign valid   = (level_q != LW'(0));
    assign level   = level_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: fetches one frame of 32-bit words over classic Wishbone
// single reads and feeds their low 24 bits to the display through a pixel FIFO.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int HDISP      = H_DISP,
    parameter int VDISP      = V_DISP,
    parameter int FIFO_DEPTH = 256
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst_n,
    input  logic [31:0]      frame_base,
    input  logic             frame_start,
    output logic [31:0]      wb_adr,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [3:0]       wb_sel,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    input  logic [31:0]      wb_dat_sm,
    input  logic             wb_ack,
    output logic [RGB_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_rd,
    output logic             underflow
);

    localparam int TOTAL = HDISP * VDISP;
    localparam int CNT_W = cnt_width(TOTAL);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    fb_state_e        state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             pending_q, pending_d;
    logic             underflow_q, underflow_d;

    logic             pend_s;
    logic             ack_s;
    logic             restart_s;
    logic             push_s;
    logic             flush_s;
    logic             pop_s;
    logic             fifo_valid_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic             unused_s;

    assign pend_s    = pending_q | frame_start;
    assign ack_s     = cyc_q & wb_ack;
    // A pending restart waits only for the in-flight read, whose data is dropped.
    assign restart_s = pend_s & (~cyc_q | wb_ack);
    assign pop_s     = pix_rd & fifo_valid_s;
    assign unused_s  = ^wb_dat_sm[31:RGB_W];

    // State and datapath registers.
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            cnt_q       <= CNT_W'(0);
            cyc_q       <= 1'b0;
            pending_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            pending_q   <= pending_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (restart_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (ack_s && (cnt_q == LAST_CNT)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Bus request, address/count and FIFO control for each state.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        pending_d   = pending_q;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        underflow_d = underflow_q | (pix_rd & ~fifo_valid_s);
        if (restart_s) begin
            flush_s   = 1'b1;
            pending_d = 1'b0;
            cyc_d     = 1'b0;
        end else begin
            pending_d = pend_s;
            case (state_q)
                ST_IDLE: begin
                    addr_d = frame_base;
                    cnt_d  = CNT_W'(0);
                    cyc_d  = 1'b0;
                end
                ST_REQ: begin
                    if (ack_s) begin
                        push_s = 1'b1;
                        cyc_d  = 1'b0;
                        addr_d = addr_q + 32'd4;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else if (!cyc_q && (fifo_level_s < LVL_W'(FIFO_DEPTH))) begin
                        cyc_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q;
                    end
                end
                ST_DONE: begin
                    cyc_d = 1'b0;
                end
                default: begin
                    cyc_d = 1'b0;
                end
            endcase
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RGB_W)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst_n   (pixel_rst_n),
        .flush   (flush_s),
        .push    (push_s),
        .wr_data (wb_dat_sm[RGB_W-1:0]),
        .pop     (pop_s),
        .rd_data (pix_data),
        .valid   (fifo_valid_s),
        .level   (fifo_level_s)
    );

    assign wb_adr    = addr_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = cyc_q;
    assign wb_we     = 1'b0;
    assign wb_sel    = 4'b1111;
    assign wb_cti    = 3'b000;
    assign wb_bte    = 2'b00;
    assign pix_valid = fifo_valid_s;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomised self-checking bench for vga_fb_reader (4x2 frame, 4-entry FIFO)
// against a transaction-level queue model of the fetch and pixel stream.
module tb_vga_fb_reader;

    localparam int HD    = 4;
    localparam int VD    = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = HD * VD;

    logic        pixel_clk;
    logic        pixel_rst_n;
    logic [31:0] frame_base;
    logic        frame_start;
    logic [31:0] wb_adr;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_rd;
    logic        underflow;

    vga_fb_reader #(.HDISP(HD), .VDISP(VD), .FIFO_DEPTH(DEPTH)) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .frame_base  (frame_base),
        .frame_start (frame_start),
        .wb_adr      (wb_adr),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_cti      (wb_cti),
        .wb_bte      (wb_bte),
        .wb_dat_sm   (wb_dat_sm),
        .wb_ack      (wb_ack),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_rd      (pix_rd),
        .underflow   (underflow)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // memory contents, indexed by pixel number within the frame
    logic [31:0] words [TOTAL];

    // reference model
    logic [23:0] mq [$];
    logic [23:0] m_last;
    bit          last_ok;
    int          m_idx;
    bit          m_pend, m_done, m_uf;
    logic [31:0] m_base;

    // slave and bookkeeping
    int          ack_dly, wait_cnt, idle_cnt, restarts, xfers;
    bit          rand_dly, stray, checks_on;
    bit          prev_req, prev_xfer, prev_stb;
    logic [31:0] prev_adr;
    logic [31:0] adr_log [$];
    logic [23:0] pop_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last   = 24'd0;
        last_ok  = 1'b1;
        m_idx    = 0;
        m_pend   = 1'b0;
        m_done   = 1'b0;
        m_uf     = 1'b0;
        m_base   = frame_base;
        prev_req = 1'b0;
        prev_xfer = 1'b0;
        prev_stb = 1'b0;
        wait_cnt = 0;
        idle_cnt = 0;
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] adr);
        logic [31:0] off;
        off = (adr - m_base) >> 2;
        if (off < TOTAL) return words[off];
        else return 32'hDEAD_BEEF;
    endfunction

    // One clock: check outputs at the falling edge, drive inputs, advance model.
    // rd_mode: 0 none, 1 pop when valid, 2 random, 3 always.
    task automatic step(input bit do_rst, input int rd_mode, input bit fs);
        bit ack_v, rd_v, xfer, pend;
        @(negedge pixel_clk);
        if (checks_on) begin
            check_eq("wb_const", {wb_we, wb_sel, wb_cti, wb_bte}, {1'b0, 4'hF, 3'd0, 2'd0});
            check_eq("cyc_eq_stb", wb_cyc, wb_stb);
            if (prev_req) begin
                check_eq("stb_hold", wb_stb, 1'b1);
                check_eq("adr_hold", wb_adr, prev_adr);
            end
            if (prev_xfer) check_eq("stb_drop", wb_stb, 1'b0);
            if (wb_stb) check_eq("adr", wb_adr, m_base + 32'(4 * m_idx));
            if (wb_stb && !prev_stb) check_eq("fifo_room", 32'(mq.size() < DEPTH), 32'd1);
            if (m_done) check_eq("done_quiet", wb_stb, 1'b0);
            check_eq("pix_valid", pix_valid, 32'(mq.size() != 0));
            if (mq.size() != 0) check_eq("pix_data", pix_data, mq[0]);
            else if (last_ok) check_eq("pix_hold", pix_data, m_last);
            check_eq("underflow", underflow, m_uf);
            if (!wb_stb && !m_done && !m_pend && mq.size() < DEPTH) idle_cnt++;
            else idle_cnt = 0;
            check_eq("fetch_stall", 32'(idle_cnt <= 6), 32'd1);
        end
        if (do_rst) begin
            pixel_rst_n = 1'b0;
            wb_ack      = 1'b0;
            pix_rd      = 1'b0;
            frame_start = 1'b0;
            model_reset();
            checks_on   = 1'b1;
        end else begin
            pixel_rst_n = 1'b1;
            if (wb_stb && !prev_stb && rand_dly) ack_dly = $urandom_range(0, 3);
            if (wb_stb) begin
                if (wait_cnt >= ack_dly) begin ack_v = 1'b1; wait_cnt = 0; end
                else begin ack_v = 1'b0; wait_cnt++; end
            end else begin
                ack_v = stray;
                wait_cnt = 0;
            end
            case (rd_mode)
                1:       rd_v = pix_valid;
                2:       rd_v = 1'($urandom_range(0, 1));
                3:       rd_v = 1'b1;
                default: rd_v = 1'b0;
            endcase
            wb_ack      = ack_v;
            wb_dat_sm   = slave_data(wb_adr);
            pix_rd      = rd_v;
            frame_start = fs;
            if (rd_v && pix_valid) pop_log.push_back(pix_data);
            // model of what the coming rising edge does
            if (rd_v && mq.size() == 0) m_uf = 1'b1;
            if (rd_v && mq.size() != 0) begin m_last = mq.pop_front(); last_ok = 1'b1; end
            xfer = wb_stb & ack_v;
            if (xfer) begin xfers++; adr_log.push_back(wb_adr); end
            pend = m_pend | fs;
            if (pend && (!wb_stb || xfer)) begin
                mq.delete();
                last_ok  = 1'b0;
                m_idx    = 0;
                m_pend   = 1'b0;
                m_done   = 1'b0;
                m_base   = frame_base;
                idle_cnt = 0;
                restarts++;
            end else begin
                m_pend = pend;
                if (xfer) begin
                    mq.push_back(words[m_idx][23:0]);
                    m_idx++;
                    if (m_idx == TOTAL) m_done = 1'b1;
                end
            end
            prev_req  = wb_stb & ~ack_v;
            prev_xfer = xfer;
            prev_stb  = wb_stb;
            prev_adr  = wb_adr;
        end
    endtask

    task automatic run(input int n, input int rd_mode);
        for (int i = 0; i < n; i++) step(1'b0, rd_mode, 1'b0);
    endtask

    task automatic wait_stb(input string tag, input int limit);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step(1'b0, 0, 1'b0);
            found = wb_stb;
        end
        check_eq(tag, found, 1'b1);
    endtask

    initial begin
        bit found;
        int x0, r0;
        pixel_rst_n = 1'b0;
        frame_base  = 32'h0000_1000;
        frame_start = 1'b0;
        wb_ack      = 1'b0;
        wb_dat_sm   = 32'd0;
        pix_rd      = 1'b0;
        ack_dly     = 1;
        rand_dly    = 1'b0;
        stray       = 1'b0;
        checks_on   = 1'b0;
        restarts    = 0;
        xfers       = 0;
        for (int i = 0; i < TOTAL; i++) words[i] = 32'h00AB_0000 + 32'(i);

        // reset state
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        check_eq("rst_cyc", wb_cyc, 1'b0);
        check_eq("rst_stb", wb_stb, 1'b0);
        check_eq("rst_adr", wb_adr, 32'd0);
        check_eq("rst_valid", pix_valid, 1'b0);
        check_eq("rst_data", pix_data, 24'd0);
        check_eq("rst_uf", underflow, 1'b0);

        // fill without popping: exactly four reads then idle
        adr_log.delete();
        run(40, 0);
        check_eq("fill_reads", adr_log.size(), 4);
        for (int i = 0; i < 4 && i < adr_log.size(); i++)
            check_eq("fill_adr", adr_log[i], 32'h1000 + 32'(4 * i));
        check_eq("fill_stb", wb_stb, 1'b0);
        check_eq("fill_valid", pix_valid, 1'b1);
        check_eq("fill_head", pix_data, 24'hAB0000);

        // drain the whole frame
        pop_log.delete();
        for (int i = 0; i < 200 && pop_log.size() < TOTAL; i++) step(1'b0, 1, 1'b0);
        check_eq("drain_count", pop_log.size(), TOTAL);
        for (int i = 0; i < TOTAL && i < pop_log.size(); i++)
            check_eq("drain_pix", pop_log[i], 24'hAB0000 + 24'(i));
        x0 = xfers;
        run(30, 1);
        check_eq("done_no_reads", xfers, x0);
        check_eq("done_valid", pix_valid, 1'b0);
        check_eq("done_uf", underflow, 1'b0);

        // underflow is sticky and leaves the last pixel on the output
        step(1'b0, 3, 1'b0);
        step(1'b0, 0, 1'b0);
        check_eq("uf_set", underflow, 1'b1);
        check_eq("uf_data", pix_data, 24'hAB0007);

        // frame_start while the read of 0x1008 is waiting for its ack
        ack_dly = 3;
        step(1'b0, 0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 0, 1'b0);
            found = wb_stb && (wb_adr == 32'h1008);
        end
        check_eq("wait_1008", found, 1'b1);
        check_eq("uf_after_fs", underflow, 1'b1);
        check_eq("pre_flush_valid", pix_valid, 1'b1);
        r0 = restarts;
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 20 && restarts == r0; i++) step(1'b0, 0, 1'b0);
        check_eq("restart_seen", restarts, r0 + 1);
        step(1'b0, 0, 1'b0);
        check_eq("flush_valid", pix_valid, 1'b0);
        wait_stb("wait_refetch", 20);
        check_eq("refetch_adr", wb_adr, 32'h1000);

        // reset in the middle of a read, then a stray ack
        check_eq("stb_before_rst", wb_stb, 1'b1);
        step(1'b1, 0, 1'b0);
        stray = 1'b1;
        step(1'b0, 0, 1'b0);
        stray = 1'b0;
        check_eq("midrst_cyc", wb_cyc, 1'b0);
        check_eq("midrst_stb", wb_stb, 1'b0);
        check_eq("midrst_valid", pix_valid, 1'b0);
        check_eq("midrst_uf", underflow, 1'b0);
        wait_stb("wait_after_rst", 20);
        check_eq("after_rst_adr", wb_adr, 32'h1000);
        run(60, 1);

        // upper byte of the memory word is dropped
        words[0] = 32'hFF12_3456;
        step(1'b1, 0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 0, 1'b0);
            found = pix_valid;
        end
        check_eq("wait_valid", found, 1'b1);
        check_eq("upper_byte", pix_data, 24'h123456);

        // randomised traffic: random data, base (incl. wrap), ack delay, pops, restarts
        ack_dly  = 0;
        rand_dly = 1'b1;
        for (int r = 0; r < 5; r++) begin
            frame_base = (r == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            for (int i = 0; i < TOTAL; i++) words[i] = $urandom();
            step(1'b1, 0, 1'b0);
            for (int i = 0; i < 600; i++)
                step(1'b0, 2, ($urandom_range(0, 63) == 0));
        end
        rand_dly = 1'b0;
        check_eq("random_reads", 32'(xfers > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter HDISP, 800, active pixels per line.
REQ-002 SHALL have parameter VDISP, 480, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, 256, pixel FIFO entries (power of 2, >=4).
REQ-004 SHALL have one clock and synchronous active-low reset: pixel_clk  in  1  sole clock; pixel_rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have frame_base  in  32  byte address of pixel (0,0) in memory.
REQ-006 SHALL have frame_start  in  1  one-cycle pulse from the display timing side requesting restart at frame_base.
REQ-007 SHALL have wb_adr  out  32  Wishbone byte address.
REQ-008 SHALL have wb_cyc, wb_stb, wb_we  out  1 each  Wishbone cycle, strobe, write enable.
REQ-009 SHALL have wb_sel  out  4, wb_cti  out  3, wb_bte  out  2  Wishbone byte select, cycle type, burst type.
REQ-010 SHALL have wb_dat_sm  in  32  read data; wb_ack  in  1  transfer acknowledge.
REQ-011 SHALL have pix_data  out  24  head-of-FIFO RGB; pix_valid  out  1  FIFO not empty; pix_rd  in  1  consumer pop.
REQ-012 SHALL have underflow  out  1  sticky: pop attempted while empty.

Function
REQ-013 SHALL drive wb_we=0, wb_sel=4'b1111, wb_cti=3'b000, wb_bte=2'b00 constantly (classic single reads only).
REQ-014 SHALL use FSM states IDLE, REQ, DONE; at most one outstanding transaction.
REQ-015 IDLE SHALL load addr=frame_base, pix_cnt=0 and go to REQ on the next cycle.
REQ-016 In REQ, SHALL assert wb_cyc=wb_stb=1 only when FIFO level < FIFO_DEPTH; once asserted, hold both with wb_adr stable until wb_ack.
REQ-017 On wb_ack SHALL push wb_dat_sm[23:0] (bits 31:24 ignored), deassert wb_cyc/wb_stb the following cycle, addr+=4, pix_cnt+=1.
REQ-018 SHALL move REQ->DONE on the ack for pix_cnt == HDISP*VDISP-1; DONE issues no requests.
REQ-019 frame_start in any state SHALL set a pending flag; the restart SHALL occur only when no transaction is outstanding (immediately if none), and an ack completing the in-flight transaction SHALL be discarded (no push).
REQ-020 Restart SHALL flush the FIFO (level=0, pix_valid=0 next cycle), clear the pending flag and enter IDLE.
REQ-021 FIFO SHALL be show-ahead: pix_data equals head whenever pix_valid=1; pop on pix_rd & pix_valid, zero added latency.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; push on full cannot occur by REQ-016.
REQ-023 pix_rd while pix_valid=0 SHALL set underflow=1 (held until reset), change nothing else; pix_data then holds its last value.
REQ-024 pix_cnt SHALL be $clog2(HDISP*VDISP) bits; addr wraps modulo 2^32 without flagging.
REQ-025 frame_start coinciding with the final ack SHALL take priority: data discarded, restart, not DONE.

Reset
REQ-026 With pixel_rst_n=0 at a pixel_clk edge: state=IDLE, wb_cyc=wb_stb=0, wb_adr=0, FIFO level=0, pix_valid=0, pix_data=0, underflow=0, pending=0, pix_cnt=0.
REQ-027 Reset asserted mid-transaction SHALL drop wb_cyc/wb_stb at the same edge; a later stray wb_ack SHALL be ignored.

Structure
REQ-028 Package vga_pkg SHALL hold the FSM state enum, the RGB width (24) and the display timing constants shared with the timing generator.
REQ-029 FIFO SHALL be sub-module pixel_fifo (single clock, synchronous active-low reset, show-ahead, level output).

Verification (HDISP=4, VDISP=2, FIFO_DEPTH=4, frame_base=0x1000, slave acks 1 cycle after stb)
REQ-030 Reset release, memory word n = 0x00AB0000+n, no pops -> 4 reads at 0x1000..0x100C, then wb_stb stays 0; pix_valid=1, pix_data=0xAB0000.
REQ-031 Continuous pix_rd from then on -> 8 pixels 0xAB0000..0xAB0007 in order, then DONE, pix_valid=0, no further wb_cyc.
REQ-032 pix_rd once after DONE with FIFO empty -> underflow=1 and stays 1 after a later frame_start.
REQ-033 frame_start while wb_stb=1 awaiting ack for 0x1008 (ack delayed 3 cycles) -> wb_stb held to ack, data not pushed, FIFO flushed, next wb_adr=0x1000.
REQ-034 pixel_rst_n=0 for one cycle while wb_stb=1 -> wb_cyc=wb_stb=0 next cycle, pix_valid=0; stray ack ignored; fetch restarts at 0x1000.
REQ-035 Word 0xFF123456 pushed -> pix_data=0x123456.
